// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: transaction owner and FSM state.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DREAD,
    OWN_DWRITE
  } arb_owner_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/ack channels plus the single memory port owned by mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned SEL_W = XLEN / 8;

  logic             i_re;
  logic [XLEN-1:0]  i_addr;
  logic             i_ack;
  logic [XLEN-1:0]  i_rdata;

  logic             dr_re;
  logic [XLEN-1:0]  dr_addr;
  logic             dr_ack;
  logic [XLEN-1:0]  dr_rdata;

  logic             dw_we;
  logic [XLEN-1:0]  dw_addr;
  logic [XLEN-1:0]  dw_wdata;
  logic [SEL_W-1:0] dw_sel;
  logic             dw_ack;

  logic             m_re;
  logic             m_we;
  logic [XLEN-1:0]  m_addr;
  logic [XLEN-1:0]  m_wdata;
  logic [SEL_W-1:0] m_sel;
  logic             m_ack;
  logic [XLEN-1:0]  m_rdata;

  logic             busy;

  // Arbiter view.
  modport slave (
    input  i_re, i_addr, dr_re, dr_addr, dw_we, dw_addr, dw_wdata, dw_sel,
    input  m_ack, m_rdata,
    output i_ack, i_rdata, dr_ack, dr_rdata, dw_ack,
    output m_re, m_we, m_addr, m_wdata, m_sel, busy
  );

  // Environment view: the three requesters and the memory together.
  modport master (
    output i_re, i_addr, dr_re, dr_addr, dw_we, dw_addr, dw_wdata, dw_sel,
    output m_ack, m_rdata,
    input  i_ack, i_rdata, dr_ack, dr_rdata, dw_ack,
    input  m_re, m_we, m_addr, m_wdata, m_sel, busy
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select: write > read > fetch, unless the data streak forces a fetch.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       instr_req_i,
  input  logic       dread_req_i,
  input  logic       dwrite_req_i,
  input  logic       streak_full_i,
  output arb_owner_t owner_c_o
);

  always_comb begin
    owner_c_o = OWN_NONE;
    if (instr_req_i && streak_full_i) begin
      owner_c_o = OWN_INSTR;
    end else if (dwrite_req_i) begin
      owner_c_o = OWN_DWRITE;
    end else if (dread_req_i) begin
      owner_c_o = OWN_DREAD;
    end else if (instr_req_i) begin
      owner_c_o = OWN_INSTR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// One-at-a-time arbiter for fetch, data read and data write onto a single memory port.
// Data wins by default; the streak counter hands the port to a waiting fetch periodically.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DATA_STREAK = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SEL_W    = XLEN / 8;
  localparam int unsigned STREAK_W = $clog2(DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  arb_owner_t          pick_c;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_re_q, m_re_d;
  logic                m_we_q, m_we_d;
  logic [XLEN-1:0]     m_addr_q, m_addr_d;
  logic [XLEN-1:0]     m_wdata_q, m_wdata_d;
  logic [SEL_W-1:0]    m_sel_q, m_sel_d;
  logic                streak_full_c;
  logic                i_ack_c, dr_ack_c, dw_ack_c;

  assign streak_full_c = (streak_q == STREAK_MAX);

  arb_pick u_pick (
    .instr_req_i   (bus.i_re),
    .dread_req_i   (bus.dr_re),
    .dwrite_req_i  (bus.dw_we),
    .streak_full_i (streak_full_c),
    .owner_c_o     (pick_c)
  );

  // State, owner, streak and latched memory-port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_NONE;
      streak_q  <= '0;
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      m_re_q    <= m_re_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_sel_q   <= m_sel_d;
    end
  end

  // Grant in IDLE, wait for m_ack in BUSY; acks pass through in the m_ack cycle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    m_re_d    = m_re_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_sel_d   = m_sel_q;
    i_ack_c   = 1'b0;
    dr_ack_c  = 1'b0;
    dw_ack_c  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_c != OWN_NONE) begin
          state_d   = ARB_BUSY;
          owner_d   = pick_c;
          m_sel_d   = '1;
          m_wdata_d = '0;
          unique case (pick_c)
            OWN_INSTR: begin
              m_re_d   = 1'b1;
              m_addr_d = bus.i_addr;
            end
            OWN_DREAD: begin
              m_re_d   = 1'b1;
              m_addr_d = bus.dr_addr;
            end
            OWN_DWRITE: begin
              m_we_d    = 1'b1;
              m_addr_d  = bus.dw_addr;
              m_wdata_d = bus.dw_wdata;
              m_sel_d   = bus.dw_sel;
            end
            default: ;
          endcase
          // Only data grants that bypass a waiting fetch extend the streak.
          if ((pick_c == OWN_INSTR) || !bus.i_re) begin
            streak_d = '0;
          end else if (!streak_full_c) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      ARB_BUSY: begin
        if (bus.m_ack) begin
          i_ack_c  = (owner_q == OWN_INSTR);
          dr_ack_c = (owner_q == OWN_DREAD);
          dw_ack_c = (owner_q == OWN_DWRITE);
          state_d  = ARB_IDLE;
          owner_d  = OWN_NONE;
          m_re_d   = 1'b0;
          m_we_d   = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.i_ack    = i_ack_c;
  assign bus.dr_ack   = dr_ack_c;
  assign bus.dw_ack   = dw_ack_c;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.dr_rdata = bus.m_rdata;
  assign bus.m_re     = m_re_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_sel    = m_sel_q;
  assign bus.busy     = (state_q == ARB_BUSY);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one memory port between the core's three bus masters: instruction fetch read, data read and data write. Sits between the core and the single-ported memory/cache, accepts at most one transaction at a time, and gives data traffic priority over fetch. A streak counter guarantees fetch progress under sustained data traffic.

## Interface
- XLEN, 32, address/data width
- DATA_STREAK, 4, maximum consecutive data grants while a fetch is pending (≥1)

- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_re  in  1  fetch read request, held until i_ack
- i_addr  in  XLEN  fetch address
- i_ack  out  1  fetch complete, one cycle
- i_rdata  out  XLEN  fetch data, valid with i_ack
- dr_re  in  1  data read request, held until dr_ack
- dr_addr  in  XLEN  data read address
- dr_ack  out  1  data read complete, one cycle
- dr_rdata  out  XLEN  read data, valid with dr_ack
- dw_we  in  1  data write request, held until dw_ack
- dw_addr  in  XLEN  write address
- dw_wdata  in  XLEN  write data
- dw_sel  in  XLEN/8  byte enables
- dw_ack  out  1  write complete, one cycle
- m_re  out  1  memory read strobe, held for the transaction
- m_we  out  1  memory write strobe, held for the transaction
- m_addr  out  XLEN  memory address
- m_wdata  out  XLEN  memory write data
- m_sel  out  XLEN/8  byte enables; all ones for reads
- m_ack  in  1  memory completion, one cycle
- m_rdata  in  XLEN  memory read data, valid with m_ack
- busy  out  1  transaction outstanding

## Operation
- States: IDLE and BUSY. The `owner` register holds NONE, INSTR, DREAD or DWRITE.
- IDLE, at least one request active:
  - Pick a winner. Priority is DWRITE > DREAD > INSTR, except that INSTR wins when i_re=1 and streak==DATA_STREAK.
  - Latch the winner's addr, wdata and sel into the m_* registers and set owner.
  - Go to BUSY.
- IDLE, no request active: stay in IDLE. All m_* strobes are 0.
- BUSY: hold m_* stable until m_ack=1.
- On m_ack in BUSY:
  - Drive the owner's ack combinationally in the same cycle. i_rdata and dr_rdata pass m_rdata through.
  - Clear the m_* strobes, set owner to NONE and return to IDLE.
- Streak counter (width $clog2(DATA_STREAK+1)):
  - A data grant made while i_re=1 increments it, saturating at DATA_STREAK.
  - An INSTR grant clears it.
  - A data grant made while i_re=0 clears it.
- Requesters must deassert their request in the cycle after their ack. The arbiter re-arbitrates from that cycle.
- Non-owner acks are always 0. rdata outputs are don't-care when their ack is 0.
- m_ack while IDLE is spurious: ignore it and raise no ack.
- Request inputs may change while BUSY. Only the latched values drive memory.
- Reset, including mid-transaction:
  - All outputs return to 0, state goes to IDLE, owner to NONE, streak to 0.
  - The outstanding memory transaction is abandoned. Memory must tolerate its strobe dropping.

## Timing
- Grant latency: a request seen in IDLE at edge N drives m_re or m_we high from cycle N+1.
- Completion: m_ack in cycle K produces the requester ack in cycle K, with zero added latency.
- Back-to-back: the next grant is decided in cycle K+1, so the next strobe rises in cycle K+2.
- Minimum transaction length is 3 cycles per access: grant, memory cycle, re-arbitrate.
- busy=1 exactly while in BUSY.
- Simultaneous dr_re and dw_we: the write goes first, the read waits in IDLE for the next arbitration.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_owner_t {OWN_NONE, OWN_INSTR, OWN_DREAD, OWN_DWRITE}
  - typedef enum logic arb_state_t {ARB_IDLE, ARB_BUSY}
- Sub-module arb_pick: combinational priority select with the streak override. Inputs are the three requests and a streak_full flag; output is arb_owner_t.
- Keep the FSM, streak counter and m_* registers in mem_arbiter.

## Test plan
- **Single fetch.** i_re=1, i_addr=0x100; m_ack one cycle later with m_rdata=0xDEADBEEF.
  - m_re=1, m_addr=0x100 from the next cycle.
  - i_ack=1, i_rdata=0xDEADBEEF in the m_ack cycle; busy drops the cycle after.
- **Write priority.** dw_we (addr 0x200, wdata 0x12345678, sel 0b0011), dr_re (0x204) and i_re (0x0) all rise in the same cycle.
  - Grant order is write (m_we=1, m_sel=0b0011), then read, then fetch.
  - Each ack goes only to its owner.
- **Starvation guard.** DATA_STREAK=4; i_re held while dr_re is re-asserted continuously.
  - Exactly 4 data grants occur, then the fetch is granted.
  - The streak then restarts from 0.
- **Stable latching.** While BUSY on dr_addr=0x40, change dr_addr to 0x80.
  - m_addr stays 0x40 until m_ack.
- **Spurious ack.** m_ack=1 while IDLE with no requests.
  - No requester ack, state stays IDLE.
- **Reset mid-transaction.** Assert reset_n=0 while BUSY with m_we=1.
  - m_we, m_re and busy go to 0 immediately (asynchronous).
  - After release, a fresh i_re is granted normally and streak=0.
